mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative multiply/divide unit directly downstream of the register file.
- Consumes the two read-port values (Qa -> A, Qb -> B) of a MULT/MULTU/DIV/DIVU/MTHI/MTLO instruction and holds the 64-bit result in architectural HI/LO registers.
- Multi-cycle with Busy/Done status. The decode/stall logic must hold dependent MFHI/MFLO and new MDU ops while Busy=1.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  synchronous reset, active-high
Start  input  1  launch the operation selected by Op, sampled only in IDLE
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
Acc  input  1  accumulate into {HI,LO} (MADD/MADDU); only used with MDU_MADD_EN
A  input  WIDTH  operand rs (from register file Qa); also data for MTHI/MTLO
B  input  WIDTH  operand rt (from register file Qb)
Mthi  input  1  write A into HI
Mtlo  input  1  write A into LO
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse: HI/LO hold the new result
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset (Rst=1 at an edge, any state, including mid-operation): state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, internal counter and working registers cleared. The in-flight operation is discarded.
- State machine: IDLE, CALC, FIX.
- IDLE, Start=1 at edge E0:
  - Latch Op and Acc.
  - For signed ops (MULT, DIV), latch |A|, |B| and the sign bits. Unsigned ops take A and B as-is.
  - Clear counter. Go to CALC. Busy=1 from this edge.
- CALC: one iteration per edge, E1..E32 (WIDTH edges). Counter counts 0..WIDTH-1; go to FIX after the edge where counter==WIDTH-1.
  - Multiply: shift-add, 2*WIDTH-bit product register.
  - Divide: restoring division, one quotient bit per cycle, remainder register WIDTH+1 bits.
- FIX (edge E33):
  - Sign correction:
    - product is negated if the operand signs differ (signed ops only);
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend A.
  - Write Hi/Lo: multiply gives Hi=product[63:32], Lo=product[31:0]; divide gives Lo=quotient, Hi=remainder.
  - Go to IDLE, Busy=0, Done=1 for exactly one cycle.
- Latency: Done is high in the cycle after E33. Busy is high for 33 cycles.
- Divide by zero (B==0, DIV or DIVU): no trap, same latency, Lo=0xFFFFFFFF, Hi=A (original, uncorrected).
- DIV overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. This is the natural result of the algorithm; no special case.
- Mthi/Mtlo:
  - Honoured only in IDLE with Start=0; written at that edge.
  - Both asserted: Hi and Lo are both written with A.
  - No Done pulse.
- Ignored events:
  - Start while Busy=1.
  - Mthi/Mtlo while Busy=1.
  - Mthi/Mtlo in the same cycle as Start: Start wins.
- Hi/Lo keep their old values throughout CALC and change only at FIX, reset, or MTHI/MTLO.
- Back-to-back: Start may be asserted in the Done cycle (state is IDLE) and is accepted.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Multiply with latched Acc=1: FIX writes {Hi,Lo} = {Hi,Lo} + product (64-bit, wraps modulo 2^64).
  - {Hi,Lo} is the value present at FIX; signed or unsigned follows Op.
  - Acc has no effect on divides.
- Undefined: the Acc port exists but is ignored; all multiplies overwrite Hi/Lo.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE, B=0x00000003 -> Busy high 33 cycles; Done pulses once; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000007.
- MTHI A=0x12345678, then Start MULTU 2*3, then Start pulse during Busy (ignored), then MTLO during Busy (ignored):
  - Hi=0x12345678 until FIX;
  - final Hi=0, Lo=6;
  - exactly one Done.
- Start DIV 100/7, assert Rst at the 10th CALC cycle -> next cycle Busy=0, Hi=Lo=0, no Done. A new MULTU 5*5 gives Lo=25 after 33 cycles.
- With MDU_MADD_EN: MTLO 10, MTHI 0, then MULTU Acc=1, 4*5 -> Lo=30, Hi=0. Without the macro the same sequence gives Lo=20.

Source files
------------

// File: rtl/mdu_iter.sv
// ============================================================================
// Module   : mdu_iter
// Purpose  : Iterative multiply/divide unit with architectural HI/LO.
//            Shift-add multiply and restoring divide, one bit per cycle,
//            followed by a sign-fix cycle that writes HI/LO.
// Option   : define MDU_MADD_EN to make multiplies with Acc=1 accumulate
//            into {HI,LO} (MADD/MADDU).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic             Acc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Mthi,
  input  logic             Mtlo,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;      // 1: divide, 0: multiply
  logic               sa_q, sa_d;        // sign of A (signed ops only)
  logic               sb_q, sb_d;        // sign of B (signed ops only)
  logic               bz_q, bz_d;        // divisor was zero
  // Multiplicand for multiplies, divisor for divides.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Product for multiplies; the low half is the dividend/quotient shifter
  // for divides.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // Partial remainder. It always stays below the divisor, so WIDTH bits
  // hold it; the trial subtraction below is WIDTH+1 bits wide.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

`ifdef MDU_MADD_EN
  logic               acc_q, acc_d;
`else
  logic               unused_acc;
  assign unused_acc = Acc;
`endif

  // Launch-time operand conditioning: magnitudes for signed ops.
  logic             start_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign start_signed = ~Op[0];
  assign abs_a = (start_signed && A[WIDTH-1]) ? -A : A;
  assign abs_b = (start_signed && B[WIDTH-1]) ? -B : B;

  // One shift-add multiply step.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring-divide step.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  assign div_shift = {rem_q, prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];

  // Sign correction applied in FIX.
  logic               neg;
  logic [2*WIDTH-1:0] prod_fix, mul_res;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign neg      = sa_q ^ sb_q;
  assign prod_fix = neg ? -prod_q : prod_q;
  // Divide by zero yields all-ones; the remainder path already returns the
  // original A because |A| re-signed with A's sign is A itself.
  assign quot_fix = bz_q ? '1 : (neg ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0]);
  assign rem_fix  = sa_q ? -rem_q : rem_q;

`ifdef MDU_MADD_EN
  assign mul_res = acc_q ? ({hi_q, lo_q} + prod_fix) : prod_fix;
`else
  assign mul_res = prod_fix;
`endif

  // Next-state and datapath update for IDLE/CALC/FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          div_d = Op[1];
          sa_d  = start_signed & A[WIDTH-1];
          sb_d  = start_signed & B[WIDTH-1];
          bz_d  = (B == '0);
          cnt_d = '0;
          rem_d = '0;
          if (Op[1]) begin
            opnd_d = abs_b;
            prod_d = {{WIDTH{1'b0}}, abs_a};
          end else begin
            opnd_d = abs_a;
            prod_d = {{WIDTH{1'b0}}, abs_b};
          end
`ifdef MDU_MADD_EN
          acc_d = Acc;
`endif
          state_d = S_CALC;
        end else begin
          if (Mthi) hi_d = A;
          if (Mtlo) lo_d = A;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          rem_d  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], div_ge};
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = mul_res[2*WIDTH-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

`default_nettype wire
